uv_recon_decode: RTL

- Decode-side counterpart of the chroma mode decision: rebuilds the 8x8 U and 8x8 V reconstruction from a chosen mode_uv and its quantized levels.
- Selects one of the four chroma predictors, dequantizes each 4x4 block, applies the VP8 inverse transform, adds the predictor and clips.
- Feeds the chroma writeback path and the encoder/decoder cross-check.
- Processes one 4x4 block per three-state FSM pass; eight blocks per macroblock.

---
 rtl/uv_recon_decode_pkg.sv | 39 +++
 rtl/itransform_pass_4.sv | 28 ++
 rtl/uv_recon_decode.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uv_recon_decode_pkg.sv
// Shared constants, FSM encoding and bus index helpers for the chroma
// reconstruction decoder.
package uv_recon_decode_pkg;

  localparam int KC1 = 85627;
  localparam int KC2 = 35468;

  localparam logic [1:0] MODE_V  = 2'd0;
  localparam logic [1:0] MODE_H  = 2'd1;
  localparam logic [1:0] MODE_TM = 2'd2;
  localparam logic [1:0] MODE_DC = 2'd3;

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_LOAD = 6'b000010,
    S_DEQ  = 6'b000100,
    S_VERT = 6'b001000,
    S_HORZ = 6'b010000,
    S_DONE = 6'b100000
  } state_e;

  // Bit offset of pixel i of block b on an 8-bit-per-pixel bus.
  function automatic int pix_base(int b, int i);
    return 8 * (16 * b + i);
  endfunction

  // Bit offset of coefficient j of block b on the 16-bit levels bus.
  function automatic int lev_base(int b, int j);
    return 16 * (16 * b + j);
  endfunction

  // Fixed-point multiply used by the transform: (x * k) >>> 16.
  function automatic logic signed [31:0] mul_k(logic signed [31:0] x, int k);
    logic signed [63:0] p;
    p = 64'(x) * 64'(k);
    return 32'(p >>> 16);
  endfunction

endpackage

// File: rtl/itransform_pass_4.sv
// One 4-point butterfly of the VP8 inverse transform (used for both the
// column and the row pass); rounding and scaling stay in the caller.
module itransform_pass_4
  import uv_recon_decode_pkg::*;
(
  input  logic signed [31:0] x0_i,
  input  logic signed [31:0] x1_i,
  input  logic signed [31:0] x2_i,
  input  logic signed [31:0] x3_i,
  output logic signed [31:0] y0_o,
  output logic signed [31:0] y1_o,
  output logic signed [31:0] y2_o,
  output logic signed [31:0] y3_o
);

  logic signed [31:0] a, b, c, d;

  assign a = x0_i + x2_i;
  assign b = x0_i - x2_i;
  assign c = mul_k(x1_i, KC2) - mul_k(x3_i, KC1);
  assign d = mul_k(x1_i, KC1) + mul_k(x3_i, KC2);

  assign y0_o = a + d;
  assign y1_o = b + c;
  assign y2_o = b - c;
  assign y3_o = a - d;

endmodule

// File: rtl/uv_recon_decode.sv
// Chroma reconstruction: latches predictor/levels/q, then per 4x4 block runs
// dequant, column pass and row pass (add predictor, clip) over eight blocks.
module uv_recon_decode
  import uv_recon_decode_pkg::*;
#(
  parameter int BLOCK_SIZE = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [31:0]                 mode_uv,
  input  logic [8*16*BLOCK_SIZE-1:0]  pred_vert,
  input  logic [8*16*BLOCK_SIZE-1:0]  pred_horz,
  input  logic [8*16*BLOCK_SIZE-1:0]  pred_tm,
  input  logic [8*16*BLOCK_SIZE-1:0]  pred_dc,
  input  logic [16*16*BLOCK_SIZE-1:0] levels,
  input  logic [16*16-1:0]            q,
  output logic [8*16*BLOCK_SIZE-1:0]  out,
  output logic                        busy,
  output logic                        done
);

  localparam int PW = 8 * 16 * BLOCK_SIZE;
  localparam int LW = 16 * 16 * BLOCK_SIZE;
  localparam int BW = $clog2(BLOCK_SIZE);

  state_e             state_q, state_d;
  logic [BW-1:0]      blk_q;
  logic [PW-1:0]      pred_q, pred_sel, out_q;
  logic [LW-1:0]      lev_q;
  logic [255:0]       q_q;
  logic signed [31:0] coeff_q [16];
  logic signed [31:0] tmp_q   [16];
  logic signed [31:0] deq     [16];
  logic signed [31:0] vert    [16];
  logic signed [31:0] horz    [16];
  logic signed [31:0] row_dc  [4];
  logic [7:0]         pix     [16];
  logic               unused_mode_hi;

  assign unused_mode_hi = ^mode_uv[31:2];

  always_comb begin
    case (mode_uv[1:0])
      MODE_V:  pred_sel = pred_vert;
      MODE_H:  pred_sel = pred_horz;
      MODE_TM: pred_sel = pred_tm;
      default: pred_sel = pred_dc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = S_DEQ;
      S_DEQ:   state_d = S_VERT;
      S_VERT:  state_d = S_HORZ;
      S_HORZ:  state_d = (blk_q == BW'(BLOCK_SIZE - 1)) ? S_DONE : S_DEQ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign out  = out_q;

  always_comb begin
    for (int j = 0; j < 16; j++) begin
      deq[j] = 32'($signed(lev_q[lev_base(int'(blk_q), j) +: 16]))
             * $signed({16'd0, q_q[16*j +: 16]});
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_pass
    itransform_pass_4 u_vert (
      .x0_i(coeff_q[k]),   .x1_i(coeff_q[k+4]),
      .x2_i(coeff_q[k+8]), .x3_i(coeff_q[k+12]),
      .y0_o(vert[4*k]),    .y1_o(vert[4*k+1]),
      .y2_o(vert[4*k+2]),  .y3_o(vert[4*k+3])
    );

    // DC rounding term for the final >>> 3 enters before the row butterfly.
    assign row_dc[k] = tmp_q[k] + 32'sd4;

    itransform_pass_4 u_horz (
      .x0_i(row_dc[k]),    .x1_i(tmp_q[k+4]),
      .x2_i(tmp_q[k+8]),   .x3_i(tmp_q[k+12]),
      .y0_o(horz[4*k]),    .y1_o(horz[4*k+1]),
      .y2_o(horz[4*k+2]),  .y3_o(horz[4*k+3])
    );
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      logic signed [31:0] sum;
      sum = $signed({24'd0, pred_q[pix_base(int'(blk_q), i) +: 8]}) + (horz[i] >>> 3);
      if (sum < 0)        pix[i] = 8'd0;
      else if (sum > 255) pix[i] = 8'd255;
      else                pix[i] = sum[7:0];
    end
  end

  // NOTE: the coefficient/transform arrays are reset too, so a reset mid-operation
  // leaves no stale state behind; the cost is a reset pin on each flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
      pred_q  <= '0;
      lev_q   <= '0;
      q_q     <= '0;
      out_q   <= '0;
      for (int j = 0; j < 16; j++) begin
        coeff_q[j] <= '0;
        tmp_q[j]   <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        S_LOAD: begin
          pred_q <= pred_sel;
          lev_q  <= levels;
          q_q    <= q;
          blk_q  <= '0;
        end
        S_DEQ:  for (int j = 0; j < 16; j++) coeff_q[j] <= deq[j];
        S_VERT: for (int j = 0; j < 16; j++) tmp_q[j] <= vert[j];
        S_HORZ: begin
          for (int i = 0; i < 16; i++) out_q[pix_base(int'(blk_q), i) +: 8] <= pix[i];
          blk_q <= blk_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
